// File: rtl/serial_subtractor.sv
// Purpose: bit-serial WIDTH-bit subtractor D = A - B, LSB first, one difference bit per clock.
// Latency: start accepted at edge k -> done/D/borrow/overflow valid in the cycle after edge k+WIDTH.
// Backpressure: none; start is honoured only in IDLE and ignored while busy or in DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_c_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // One full-subtractor cell fed from the low bits of the operand shift registers.
  assign w_a       = r_a[0];
  assign w_b       = r_b[0];
  assign w_d       = w_a ^ w_b ^ r_c;
  assign w_c_nxt   = (~w_a & w_b) | (~(w_a ^ w_b) & r_c);
  assign w_last    = (r_cnt == LAST);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // State register; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit, DONE -> IDLE always.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per cycle, publish the result on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_res <= w_res_nxt;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Published results persist until the next operation finishes.
            r_d      <= w_res_nxt;
            r_borrow <= w_c_nxt;
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            r_ovf    <= r_c ^ w_c_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags are plain decodes of the state flops, so no input reaches an output combinationally.
  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign D        = r_d;
  assign borrow   = r_borrow;
  assign overflow = r_ovf;

endmodule
